tx_controller: RTL and testbench
================================

# tx_controller

Sequencing controller for the UART transmit engine's 11-bit parallel-in/serial-out shift register.
- Accepts a byte from the host with a write strobe.
- Builds the 11-bit frame: start bit, 7 or 8 data bits, optional odd/even parity, stop bits.
- Drives the register's `ld` and `sh_en` at the programmed bit time, and reports ready/done to the host.
- Sits in the TxEngine between the host register interface and the shift register. The shift register's `ser_in` is tied to 1 at the TxEngine level.

## Interface
Parameters: none (widths fixed in `uart_tx_pkg`).

- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `write`  in  1  host write strobe; sampled only in IDLE.
- `data_in`  in  8  byte to transmit.
- `eight`  in  1  1 = 8 data bits, 0 = 7 bits (`data_in[6:0]`).
- `pen`  in  1  parity enable.
- `ohel`  in  1  1 = odd parity, 0 = even parity.
- `k`  in  19  bit time in `Clk` cycles; values 0 and 1 are treated as 2.
- `ld`  out  1  load strobe to the shift register.
- `sh_en`  out  1  shift strobe, one cycle per bit time.
- `frame_out`  out  11  parallel frame to the shift register, LSB transmitted first.
- `tx_rdy`  out  1  high while a write will be accepted.
- `tx_done`  out  1  one-cycle pulse at frame completion.

## Operation
**States**
- INIT:
  - `ld`=1, `frame_out`=11'h7FF (forces the line idle-high after reset).
  - Next state IDLE.
- IDLE:
  - `tx_rdy`=1.
  - On `write`=1: latch the built frame; next state LOAD.
- LOAD:
  - `ld`=1, `frame_out`=latched frame.
  - Clear baud counter and bit counter; next state SHIFT.
- SHIFT:
  - Baud counter counts 0..k'-1, where k' = max(k, 2).
  - At count k'-1: `sh_en`=1, counter returns to 0, bit counter increments.
  - After the 11th `sh_en`: next state DONE.
- DONE:
  - `tx_done`=1 for one cycle; next state IDLE.

**Frame build** (bit 10 down to bit 0; `d` = `data_in` captured at write)
- eight=1, pen=1: {1, P, d[7:0], 0}
- eight=1, pen=0: {1, 1, d[7:0], 0}
- eight=0, pen=1: {1, 1, P, d[6:0], 0}
- eight=0, pen=0: {1, 1, 1, d[6:0], 0}

**Parity P**
- Computed over the active data bits only.
- Even: XOR of the active bits. Odd: XNOR of the active bits.

**Rules**
- `eight`, `pen`, `ohel` and `data_in` are sampled only on the accepted write edge. Later changes do not affect the frame in flight.
- `k` is sampled continuously. Changing it mid-frame is unsupported.
- `write` outside IDLE, including in DONE, is ignored, with no queuing.
- All outputs are Moore decodes of the state register, plus baud-counter terminal count for `sh_en`.
- `frame_out` is 11'h7FF outside LOAD.

## Timing
**Reset**
- Reset (async) forces state INIT.
- During reset: `ld`=1, `frame_out`=11'h7FF, `sh_en`=0, `tx_rdy`=0, `tx_done`=0.
- First edge after release leaves INIT. `tx_rdy` rises one cycle after release.

**Frame sequence**
- `write` sampled at edge n.
- LOAD occupies cycle n+1, and the shift register loads at its end.
- The start bit is on the line from cycle n+2 for k' cycles.
- Each later bit also lasts k' cycles.
- The first `sh_en` occurs k' cycles after LOAD. `sh_en` pulses are exactly k' cycles apart, 11 in total.
- DONE follows the cycle of the 11th `sh_en`.
- `tx_rdy` is low for 11·k'+2 cycles per frame.
- Back-to-back frames: a write in the first IDLE cycle gives no extra idle bit time beyond stop bits.

**Reset mid-frame**
- Immediate return to INIT.
- Counters cleared, no `tx_done`, frame discarded. The line returns high through the INIT load.

## Structure
- Package `uart_tx_pkg`:
  - state encoding (INIT, IDLE, LOAD, SHIFT, DONE)
  - `FRAME_W`=11, `K_W`=19, `BIT_CNT_W`=4
  - `IDLE_FRAME`=11'h7FF, `K_MIN`=2
- Sub-module `tx_frame_builder`: combinational `data_in`/`eight`/`pen`/`ohel` → 11-bit frame, including parity.
- The FSM, baud counter and bit counter stay in `tx_controller`.

## Test plan
- Reset release, k=4:
  - One INIT cycle with `ld`=1 and `frame_out`=11'h7FF.
  - Then `tx_rdy`=1 and no `sh_en`.
- k=4, eight=1, pen=1, ohel=0, data 8'h55, write:
  - LOAD with `frame_out`=11'h4AA.
  - 11 `sh_en` pulses 4 cycles apart.
  - `tx_done` on the cycle after the last pulse.
  - `tx_rdy` low for 46 cycles.
- k=4, eight=0, pen=1, ohel=1, data 8'h41: `frame_out`=11'h782 (odd parity bit 1).
- Second `write` asserted mid-SHIFT and again in DONE: both ignored, no second LOAD until a write in IDLE.
- `Rst` asserted after the 5th `sh_en`:
  - Immediate INIT outputs, no further `sh_en`, no `tx_done`.
  - After release: INIT, then IDLE.
- k=0 and k=1: `sh_en` every 2 cycles; `tx_rdy` low 24 cycles per frame.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared widths, constants and FSM encoding for the UART transmit
// sequencing logic (tx_controller and tx_frame_builder).
package uart_tx_pkg;

  localparam int unsigned FRAME_W   = 11;
  localparam int unsigned K_W       = 19;
  localparam int unsigned BIT_CNT_W = 4;

  localparam logic [FRAME_W-1:0]   IDLE_FRAME = 11'h7FF;
  localparam logic [K_W-1:0]       K_MIN      = 19'd2;
  // Bit counter value when the 11th (final) shift fires.
  localparam logic [BIT_CNT_W-1:0] LAST_BIT   = 4'd10;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StLoad,
    StShift,
    StDone
  } tx_state_e;

  // Bit times below K_MIN cannot be honoured by the counter, so clamp them.
  function automatic logic [K_W-1:0] eff_bit_time(input logic [K_W-1:0] k);
    return (k < K_MIN) ? K_MIN : k;
  endfunction

endpackage

// File: rtl/tx_frame_builder.sv
// tx_frame_builder: combinational builder of the 11-bit UART frame
// (start bit, 7 or 8 data bits, optional parity, stop bits), LSB sent first.
// Ports:
//   data_in  in  8   byte to send (bit 7 ignored when eight=0)
//   eight    in  1   1 = 8 data bits, 0 = 7 data bits
//   pen      in  1   parity enable
//   ohel     in  1   1 = odd parity, 0 = even parity
//   frame    out 11  assembled frame; unused positions are stop-level 1s
module tx_frame_builder
  import uart_tx_pkg::*;
(
  input  logic [7:0]         data_in,
  input  logic               eight,
  input  logic               pen,
  input  logic               ohel,
  output logic [FRAME_W-1:0] frame
);

  logic [7:0] active_bits;
  logic       parity;

  // Masking bit 7 lets a single reduction cover both data widths.
  assign active_bits = eight ? data_in : {1'b0, data_in[6:0]};
  assign parity      = (^active_bits) ^ ohel;

  always_comb begin
    frame    = IDLE_FRAME;
    frame[0] = 1'b0;
    if (eight) begin
      frame[8:1] = data_in;
      if (pen) frame[9] = parity;
    end else begin
      frame[7:1] = data_in[6:0];
      if (pen) frame[8] = parity;
    end
  end

endmodule

// File: rtl/tx_controller.sv
// tx_controller: sequencing FSM for the UART transmit shift register.
// Accepts a byte on write (IDLE only), loads the built frame, then issues one
// shift strobe per bit time for all 11 frame bits and pulses tx_done.
// Ports:
//   Clk        in  1   system clock, rising edge
//   Rst        in  1   asynchronous active-low reset
//   write      in  1   host write strobe, honoured only in IDLE
//   data_in    in  8   byte to transmit
//   eight      in  1   1 = 8 data bits, 0 = 7 data bits
//   pen        in  1   parity enable
//   ohel       in  1   1 = odd parity, 0 = even parity
//   k          in  19  bit time in Clk cycles (0 and 1 behave as 2)
//   ld         out 1   shift-register load strobe
//   sh_en      out 1   shift strobe, one per bit time
//   frame_out  out 11  parallel frame for the shift register
//   tx_rdy     out 1   high while a write will be accepted
//   tx_done    out 1   one-cycle pulse at frame completion
module tx_controller
  import uart_tx_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst,
  input  logic               write,
  input  logic [7:0]         data_in,
  input  logic               eight,
  input  logic               pen,
  input  logic               ohel,
  input  logic [K_W-1:0]     k,
  output logic               ld,
  output logic               sh_en,
  output logic [FRAME_W-1:0] frame_out,
  output logic               tx_rdy,
  output logic               tx_done
);

  tx_state_e              state_q, state_d;
  logic [K_W-1:0]         baud_q, baud_d;
  logic [BIT_CNT_W-1:0]   bit_q, bit_d;
  logic [K_W-1:0]         k_eff;
  logic [FRAME_W-1:0]     frame_built;

  logic                   ld_q;
  logic                   sh_en_q;
  logic [FRAME_W-1:0]     frame_q;
  logic                   tx_rdy_q;
  logic                   tx_done_q;

  tx_frame_builder u_frame_builder (
    .data_in (data_in),
    .eight   (eight),
    .pen     (pen),
    .ohel    (ohel),
    .frame   (frame_built)
  );

  assign k_eff = eff_bit_time(k);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    unique case (state_q)
      StInit: state_d = StIdle;
      StIdle: if (write) state_d = StLoad;
      StLoad: begin
        state_d = StShift;
        baud_d  = '0;
        bit_d   = '0;
      end
      StShift: begin
        // >= rather than == so a shrunken k cannot strand the counter.
        if (baud_q >= k_eff - 19'd1) begin
          baud_d = '0;
          bit_d  = bit_q + 4'd1;
          if (bit_q == LAST_BIT) state_d = StDone;
        end else begin
          baud_d = baud_q + 19'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StInit;
    endcase
  end

  // Outputs are registered from the next state, so each one is a clean
  // decode of the state held in the following cycle. The frame is captured
  // only on the IDLE->LOAD transition, i.e. on the accepted write edge.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= StInit;
      baud_q    <= '0;
      bit_q     <= '0;
      ld_q      <= 1'b1;
      frame_q   <= IDLE_FRAME;
      sh_en_q   <= 1'b0;
      tx_rdy_q  <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      ld_q      <= (state_d == StInit) || (state_d == StLoad);
      frame_q   <= (state_d == StLoad) ? frame_built : IDLE_FRAME;
      sh_en_q   <= (state_d == StShift) && (baud_d == k_eff - 19'd1);
      tx_rdy_q  <= (state_d == StIdle);
      tx_done_q <= (state_d == StDone);
    end
  end

  assign ld        = ld_q;
  assign sh_en     = sh_en_q;
  assign frame_out = frame_q;
  assign tx_rdy    = tx_rdy_q;
  assign tx_done   = tx_done_q;

endmodule

// File: tb/tb_tx_controller.sv
// tb_tx_controller: scoreboard bench for tx_controller. The stimulus process
// issues frames on its own model timeline and pushes the expected frame and
// bit time; an independent monitor checks loads, shift spacing, completion
// timing, idle outputs and reset behaviour.
module tb_tx_controller;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        write;
  logic [7:0]  data_in;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [18:0] k;
  logic        ld;
  logic        sh_en;
  logic [10:0] frame_out;
  logic        tx_rdy;
  logic        tx_done;

  typedef struct {
    logic [10:0] frame;
    int          kp;
    int          abort_at;
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  tx_controller dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .write     (write),
    .data_in   (data_in),
    .eight     (eight),
    .pen       (pen),
    .ohel      (ohel),
    .k         (k),
    .ld        (ld),
    .sh_en     (sh_en),
    .frame_out (frame_out),
    .tx_rdy    (tx_rdy),
    .tx_done   (tx_done)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame straight from the frame rules: start 0, data LSB first,
  // parity right after the data when enabled, everything else stop-level 1.
  function automatic logic [10:0] frame_model(input logic [7:0] d, input logic e,
                                              input logic p, input logic o);
    int          n    = e ? 8 : 7;
    int          ones = 0;
    logic [10:0] f    = 11'h7FF;
    f[0] = 1'b0;
    for (int i = 0; i < n; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    if (p) f[1+n] = (1'(ones % 2)) ^ o;
    return f;
  endfunction

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  bit   in_flight   = 1'b0;
  bit   after_reset = 1'b0;
  int   cnt, sh, last_sh;
  txn_t cur;

  always @(negedge Clk) begin
    if (!Rst) begin
      if (in_flight) begin
        check("abort_shen_count", sh, cur.abort_at);
        in_flight = 1'b0;
      end
      check("reset_outputs", 32'({ld, sh_en, tx_rdy, tx_done, frame_out}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF}));
      after_reset = 1'b1;
    end else if (after_reset) begin
      check("init_after_release", 32'({ld, sh_en, tx_rdy, tx_done, frame_out}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF}));
      after_reset = 1'b0;
    end else if (ld) begin
      check("load_expected", 32'(exp_q.size() != 0 && !in_flight), 1);
      if (exp_q.size() != 0) begin
        cur = exp_q.pop_front();
        check("load_frame", 32'(frame_out), 32'(cur.frame));
        check("load_flags", 32'({tx_rdy, sh_en, tx_done}), 0);
        in_flight = 1'b1;
        cnt       = 1;
        sh        = 0;
        last_sh   = 1;
      end
    end else if (in_flight) begin
      cnt++;
      if (tx_rdy) check("rdy_low_in_frame", 32'(tx_rdy), 0);
      if (sh_en) begin
        sh++;
        check("shen_spacing", cnt - last_sh, cur.kp);
        last_sh = cnt;
      end
      if (tx_done) begin
        check("done_after_11_shifts", sh, 11);
        check("done_cycle", cnt, 11 * cur.kp + 2);
        check("done_not_aborted", cur.abort_at, 0);
        in_flight = 1'b0;
      end else if (cnt > 11 * cur.kp + 8) begin
        check("done_timeout", cnt, 11 * cur.kp + 2);
        in_flight = 1'b0;
      end
    end else begin
      check("idle_outputs", 32'({tx_rdy, sh_en, tx_done, frame_out}),
            32'({1'b1, 1'b0, 1'b0, 11'h7FF}));
    end
  end

  // ---------------- stimulus ----------------
  task automatic scramble_inputs();
    data_in = 8'($urandom);
    eight   = 1'($urandom_range(0, 1));
    pen     = 1'($urandom_range(0, 1));
    ohel    = 1'($urandom_range(0, 1));
  endtask

  // Send one frame. poke re-asserts write mid-SHIFT and in DONE (must be
  // ignored). abort_at > 0 asserts reset right after that many shifts.
  task automatic send(input logic [7:0] d, input logic e, input logic p, input logic o,
                      input logic [18:0] kk, input int abort_at, input bit poke);
    int   kp;
    txn_t t;
    kp      = (kk < 19'd2) ? 2 : int'(kk);
    k       = kk;
    data_in = d;
    eight   = e;
    pen     = p;
    ohel    = o;
    write   = 1'b1;
    t.frame    = frame_model(d, e, p, o);
    t.kp       = kp;
    t.abort_at = abort_at;
    exp_q.push_back(t);
    cyc();
    write = 1'b0;
    scramble_inputs();
    if (abort_at == 0) begin
      for (int i = 0; i < 11 * kp + 2; i++) begin
        write = poke && (i == 3 || i == 11 * kp + 1);
        cyc();
      end
      write = 1'b0;
    end else begin
      repeat (abort_at * kp) cyc();
      #6;
      Rst = 1'b0;
      #1;
      check("rst_immediate", 32'({ld, sh_en, tx_rdy, tx_done, frame_out}),
            32'({1'b1, 1'b0, 1'b0, 1'b0, 11'h7FF}));
      cyc();
      cyc();
      Rst = 1'b1;
      cyc();
    end
  endtask

  initial begin
    Rst     = 1'b0;
    write   = 1'b0;
    data_in = 8'h00;
    eight   = 1'b1;
    pen     = 1'b0;
    ohel    = 1'b0;
    k       = 19'd4;
    repeat (3) cyc();
    Rst = 1'b1;
    cyc();
    repeat (3) cyc();

    send(8'h55, 1'b1, 1'b1, 1'b0, 19'd4, 0, 1'b1);
    send(8'h41, 1'b0, 1'b1, 1'b1, 19'd4, 0, 1'b0);
    repeat (2) cyc();
    send(8'hA7, 1'b1, 1'b0, 1'b0, 19'd0, 0, 1'b1);
    send(8'h3C, 1'b0, 1'b0, 1'b1, 19'd1, 0, 1'b0);
    send(8'hF0, 1'b1, 1'b1, 1'b1, 19'd3, 5, 1'b0);
    repeat (2) cyc();

    for (int n = 0; n < 20; n++) begin
      send(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 19'($urandom_range(0, 6)), 0,
           1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) cyc();
    end

    repeat (5) cyc();
    check("queue_drained", exp_q.size(), 0);
    check("nothing_in_flight", 32'(in_flight), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
